// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one UART transmitter between several byte-stream
// requesters (screen refresh, cursor echo, escape-sequence generation).
// Ownership is held for a whole packet so multi-byte sequences are never
// interleaved. Bytes are paced on the transmitter's done pulse, fairness
// rotates round-robin at packet boundaries, and an owner that goes quiet
// mid-packet is dropped after TIMEOUT cycles.

module tx_arbiter #(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [8*NREQ-1:0]   i_req_byte,
   input  logic [NREQ-1:0]     i_req_v,
   input  logic [NREQ-1:0]     i_req_last,
   output logic [NREQ-1:0]     o_req_ack,
   output logic [NREQ-1:0]     o_grant,
   output logic [7:0]          o_byte,
   output logic                o_byte_v,
   input  logic                i_tx_active,
   input  logic                i_tx_done,
   output logic                o_err
);

   // Index and stall-counter widths; both kept at least one bit wide.
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DONE,
      HOLD
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_owner;
   logic            r_last;
   logic [CW-1:0]   r_count;

   logic [NREQ-1:0] r_req_ack;
   logic [NREQ-1:0] r_grant;
   logic [7:0]      r_byte;
   logic            r_byte_v;
   logic            r_err;

   logic [NREQ-1:0] w_rot;
   logic [IW-1:0]   w_off;
   logic [IW:0]     w_sum;
   logic [IW-1:0]   w_pick;
   logic            w_any;
   logic [7:0]      w_pickByte;
   logic            w_pickLast;
   logic            w_ownerV;
   logic [7:0]      w_ownerByte;
   logic            w_ownerLast;
   logic [IW-1:0]   w_ownerNext;

   // Round-robin search: rotate the request vector so the pointer lands on
   // bit 0, take the lowest set bit, then rotate the offset back.
   always_comb begin
      w_rot = NREQ'({i_req_v, i_req_v} >> r_ptr);
      w_off = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_off = IW'(j);
         end
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= (IW + 1)'(NREQ)) begin
         w_pick = IW'(w_sum - (IW + 1)'(NREQ));
      end else begin
         w_pick = IW'(w_sum);
      end
      w_any = |i_req_v;
   end

   // Data and flags of the winning requester and of the current owner.
   always_comb begin
      w_pickByte  = i_req_byte[{w_pick, 3'b000} +: 8];
      w_pickLast  = i_req_last[w_pick];
      w_ownerV    = i_req_v[r_owner];
      w_ownerByte = i_req_byte[{r_owner, 3'b000} +: 8];
      w_ownerLast = i_req_last[r_owner];
      if (r_owner == IW'(NREQ - 1)) begin
         w_ownerNext = '0;
      end else begin
         w_ownerNext = r_owner + 1'b1;
      end
   end

   // Main arbiter FSM: issues bytes, waits for the transmitter, holds the
   // channel between bytes of a packet and releases on last byte or stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_last    <= 1'b0;
         r_count   <= '0;
         r_req_ack <= '0;
         r_grant   <= '0;
         r_byte    <= '0;
         r_byte_v  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_req_ack <= '0;
         r_byte_v  <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any && !i_tx_active) begin
                  r_owner   <= w_pick;
                  r_byte    <= w_pickByte;
                  r_byte_v  <= 1'b1;
                  r_req_ack <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                  r_grant   <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                  r_last    <= w_pickLast;
                  r_state   <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i_tx_done) begin
                  if (r_last) begin
                     r_grant <= '0;
                     r_ptr   <= w_ownerNext;
                     r_state <= IDLE;
                  end else begin
                     r_count <= '0;
                     r_state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (w_ownerV && !i_tx_active) begin
                  r_byte    <= w_ownerByte;
                  r_byte_v  <= 1'b1;
                  r_req_ack <= r_grant;
                  r_last    <= w_ownerLast;
                  r_state   <= WAIT_DONE;
               end else if (r_count == CW'(TIMEOUT - 1)) begin
                  r_grant <= '0;
                  r_err   <= 1'b1;
                  r_ptr   <= w_ownerNext;
                  r_state <= IDLE;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_req_ack = r_req_ack;
   assign o_grant   = r_grant;
   assign o_byte    = r_byte;
   assign o_byte_v  = r_byte_v;
   assign o_err     = r_err;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed scenarios for the UART transmit arbiter with
// three requesters and a short stall timeout of 16 cycles.

module tb_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [23:0] reqByte;
   logic [2:0]  reqV;
   logic [2:0]  reqLast;
   logic [2:0]  reqAck;
   logic [2:0]  grant;
   logic [7:0]  txByte;
   logic        txByteV;
   logic        txActive;
   logic        txDone;
   logic        err;

   int errors;
   int checks;
   int ackCnt [3];
   int grantLog [$];
   logic [7:0] byteLog [$];
   int errPulses;

   tx_arbiter #(.NREQ(3), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_byte  (reqByte),
      .i_req_v     (reqV),
      .i_req_last  (reqLast),
      .o_req_ack   (reqAck),
      .o_grant     (grant),
      .o_byte      (txByte),
      .o_byte_v    (txByteV),
      .i_tx_active (txActive),
      .i_tx_done   (txDone),
      .o_err       (err)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int oneHotIdx(input logic [2:0] v);
      int idx;
      idx = -1;
      for (int k = 0; k < 3; k++) if (v[k]) idx = k;
      return idx;
   endfunction

   // Advance one clock edge and log what the DUT did on that edge
   task automatic stepClock();
      @(posedge clk);
      #1;
      if (txByteV === 1'b1) begin
         byteLog.push_back(txByte);
         grantLog.push_back(oneHotIdx(grant));
      end
      for (int k = 0; k < 3; k++) if (reqAck[k] === 1'b1) ackCnt[k]++;
      if (err === 1'b1) errPulses++;
   endtask

   task automatic applyReset();
      rst      = 1'b1;
      reqV     = '0;
      reqLast  = '0;
      reqByte  = '0;
      txActive = 1'b0;
      txDone   = 1'b0;
      stepClock();
      stepClock();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) ackCnt[k] = 0;
      grantLog.delete();
      byteLog.delete();
      errPulses = 0;
   endtask

   task automatic test_reset();
      applyReset();
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 000", grant); end
      checks++; if (txByteV !== 1'b0) begin errors++; $display("[TB] FAIL reset_byte_v: got %b expected 0", txByteV); end
      checks++; if (reqAck !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 000", reqAck); end
      checks++; if (txByte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte: got %h expected 00", txByte); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
   endtask

   task automatic test_single_packet();
      logic [7:0] exp [3];
      exp = '{8'h1B, 8'h5B, 8'h48};
      applyReset();
      reqV = 3'b001; reqLast = 3'b000; reqByte[7:0] = 8'h1B;
      stepClock();
      checks++; if (txByteV !== 1'b1) begin errors++; $display("[TB] FAIL single_first_issue: got %b expected 1", txByteV); end
      checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL single_grant0: got %b expected 001", grant); end
      reqByte[7:0] = 8'h5B;
      stepClock();
      checks++; if (txByteV !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width: got %b expected 0", txByteV); end
      checks++; if (reqAck !== 3'b000) begin errors++; $display("[TB] FAIL single_ack_width: got %b expected 000", reqAck); end
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      checks++; if (txByteV !== 1'b0) begin errors++; $display("[TB] FAIL single_gap1_early: got %b expected 0", txByteV); end
      stepClock();
      checks++; if (txByteV !== 1'b1) begin errors++; $display("[TB] FAIL single_gap1_issue: got %b expected 1", txByteV); end
      reqByte[7:0] = 8'h48; reqLast = 3'b001;
      stepClock();
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      stepClock();
      checks++; if (txByteV !== 1'b1) begin errors++; $display("[TB] FAIL single_gap2_issue: got %b expected 1", txByteV); end
      reqV = 3'b000; reqLast = 3'b000;
      stepClock();
      checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL single_grant_held: got %b expected 001", grant); end
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL single_release: got %b expected 000", grant); end
      stepClock();
      checks++; if (ackCnt[0] !== 3) begin errors++; $display("[TB] FAIL single_ack_count: got %0d expected 3", ackCnt[0]); end
      checks++; if (byteLog.size() !== 3) begin errors++; $display("[TB] FAIL single_byte_count: got %0d expected 3", byteLog.size()); end
      for (int i = 0; i < 3 && i < byteLog.size(); i++) begin
         checks++; if (byteLog[i] !== exp[i]) begin errors++; $display("[TB] FAIL single_byte%0d: got %h expected %h", i, byteLog[i], exp[i]); end
      end
   endtask

   task automatic test_two_requesters();
      applyReset();
      reqV = 3'b101; reqLast = 3'b100; reqByte = {8'hC0, 8'h00, 8'hA0};
      stepClock();
      checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL two_first_grant: got %b expected 001", grant); end
      checks++; if (reqAck !== 3'b001) begin errors++; $display("[TB] FAIL two_first_ack: got %b expected 001", reqAck); end
      checks++; if (txByte !== 8'hA0) begin errors++; $display("[TB] FAIL two_first_byte: got %h expected a0", txByte); end
      reqByte[7:0] = 8'hA1; reqLast = 3'b101;
      reqV[2] = 1'b0; stepClock(); reqV[2] = 1'b1;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      stepClock();
      checks++; if (reqAck !== 3'b001) begin errors++; $display("[TB] FAIL two_second_ack: got %b expected 001", reqAck); end
      checks++; if (txByte !== 8'hA1) begin errors++; $display("[TB] FAIL two_second_byte: got %h expected a1", txByte); end
      reqV[0] = 1'b0;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL two_release: got %b expected 000", grant); end
      checks++; if (ackCnt[2] !== 0) begin errors++; $display("[TB] FAIL two_req2_not_acked: got %0d expected 0", ackCnt[2]); end
      stepClock();
      checks++; if (grant !== 3'b100) begin errors++; $display("[TB] FAIL two_req2_grant: got %b expected 100", grant); end
      checks++; if (txByte !== 8'hC0) begin errors++; $display("[TB] FAIL two_req2_byte: got %h expected c0", txByte); end
      reqV = 3'b000;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      reqV = 3'b011; reqLast = 3'b011; reqByte = {8'h00, 8'hB1, 8'hB0};
      stepClock();
      checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL two_ptr_wrap: got %b expected 001", grant); end
      reqV = 3'b000;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
   endtask

   task automatic test_round_robin();
      applyReset();
      reqV = 3'b111; reqLast = 3'b111; reqByte = {8'h30, 8'h20, 8'h10};
      stepClock();
      for (int p = 0; p < 5; p++) begin
         txDone = 1'b1; stepClock(); txDone = 1'b0;
         stepClock();
      end
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      reqV = 3'b000;
      stepClock();
      checks++; if (grantLog.size() !== 6) begin errors++; $display("[TB] FAIL rr_count: got %0d expected 6", grantLog.size()); end
      for (int i = 0; i < 6 && i < grantLog.size(); i++) begin
         checks++; if (grantLog[i] !== (i % 3)) begin errors++; $display("[TB] FAIL rr_order%0d: got %0d expected %0d", i, grantLog[i], i % 3); end
      end
      for (int i = 1; i < grantLog.size(); i++) begin
         checks++; if (grantLog[i] === grantLog[i-1]) begin errors++; $display("[TB] FAIL rr_repeat%0d: got %0d expected not %0d", i, grantLog[i], grantLog[i-1]); end
      end
   endtask

   task automatic test_timeout();
      int errAt;
      applyReset();
      reqV = 3'b011; reqLast = 3'b010; reqByte = {8'h00, 8'h22, 8'h11};
      stepClock();
      checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL to_owner: got %b expected 001", grant); end
      reqV[0] = 1'b0;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      errAt = -1;
      for (int k = 1; k <= 20; k++) begin
         stepClock();
         if (err === 1'b1) begin
            errAt = k;
            break;
         end
      end
      checks++; if (errAt !== 16) begin errors++; $display("[TB] FAIL to_err_cycle: got %0d expected 16", errAt); end
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL to_release: got %b expected 000", grant); end
      checks++; if (ackCnt[1] !== 0) begin errors++; $display("[TB] FAIL to_req1_waiting: got %0d expected 0", ackCnt[1]); end
      stepClock();
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_width: got %b expected 0", err); end
      checks++; if (grant !== 3'b010) begin errors++; $display("[TB] FAIL to_next_grant: got %b expected 010", grant); end
      checks++; if (txByte !== 8'h22) begin errors++; $display("[TB] FAIL to_next_byte: got %h expected 22", txByte); end
      reqV = 3'b000;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      checks++; if (errPulses !== 1) begin errors++; $display("[TB] FAIL to_err_pulses: got %0d expected 1", errPulses); end
   endtask

   task automatic test_tx_active();
      logic sawIssue;
      applyReset();
      txActive = 1'b1; reqV = 3'b001; reqLast = 3'b001; reqByte[7:0] = 8'h55;
      sawIssue = 1'b0;
      for (int k = 0; k < 10; k++) begin
         stepClock();
         if (txByteV === 1'b1) sawIssue = 1'b1;
      end
      checks++; if (sawIssue !== 1'b0) begin errors++; $display("[TB] FAIL act_deferred: got %b expected 0", sawIssue); end
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL act_no_grant: got %b expected 000", grant); end
      txActive = 1'b0;
      stepClock();
      checks++; if (txByteV !== 1'b1) begin errors++; $display("[TB] FAIL act_issue: got %b expected 1", txByteV); end
      checks++; if (txByte !== 8'h55) begin errors++; $display("[TB] FAIL act_byte: got %h expected 55", txByte); end
      reqV = 3'b000;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      applyReset();
      reqV = 3'b001; reqLast = 3'b000; reqByte = {8'h00, 8'h00, 8'h33};
      stepClock();
      checks++; if (grant !== 3'b001) begin errors++; $display("[TB] FAIL rstm_owner: got %b expected 001", grant); end
      rst = 1'b1;
      stepClock();
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL rstm_grant: got %b expected 000", grant); end
      checks++; if (txByteV !== 1'b0) begin errors++; $display("[TB] FAIL rstm_byte_v: got %b expected 0", txByteV); end
      checks++; if (reqAck !== 3'b000) begin errors++; $display("[TB] FAIL rstm_ack: got %b expected 000", reqAck); end
      checks++; if (txByte !== 8'h00) begin errors++; $display("[TB] FAIL rstm_byte: got %h expected 00", txByte); end
      rst = 1'b0; reqV = 3'b000;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      stepClock();
      checks++; if (txByteV !== 1'b0) begin errors++; $display("[TB] FAIL rstm_stale_done: got %b expected 0", txByteV); end
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL rstm_stale_grant: got %b expected 000", grant); end
      reqV = 3'b110; reqLast = 3'b110; reqByte = {8'h77, 8'h66, 8'h33};
      stepClock();
      checks++; if (grant !== 3'b010) begin errors++; $display("[TB] FAIL rstm_fresh_grant: got %b expected 010", grant); end
      checks++; if (txByte !== 8'h66) begin errors++; $display("[TB] FAIL rstm_fresh_byte: got %h expected 66", txByte); end
      reqV = 3'b000;
      txDone = 1'b1; stepClock(); txDone = 1'b0;
      checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL rstm_fresh_release: got %b expected 000", grant); end
   endtask

   // Run every scenario in order, then report
   initial begin
      errors = 0;
      checks = 0;
      errPulses = 0;
      test_reset();
      test_single_packet();
      test_two_requesters();
      test_round_robin();
      test_timeout();
      test_tx_active();
      test_reset_mid_packet();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
